// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide, sign fix-up.
// Optional macro MULDIV_EARLY_OUT_EN adds PREP fast paths (zero multiplies, |A|<|B| divides).
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] Q,
    output logic [2:0]       dbg_state
);

    // Handshake: start is taken only in IDLE (flush low); busy is high outside IDLE;
    // valid is a single-cycle pulse in DONE with Q holding the result until the next valid.
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   a_reg, b_reg, mag_d, rem;
    logic [2:0]         op_reg;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg_q, neg_r;

    logic               is_div, a_signed, b_signed, sa, sb;
    logic [WIDTH-1:0]   mag_a_c, mag_b_c;
    logic               spec_hit;
    logic [WIDTH-1:0]   spec_val;
    logic [WIDTH:0]     mul_sum, shifted, diff;
    logic               ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_val, load_val;
    logic               load_q;

    // Operand signedness: MUL is treated as signed since its low word does not depend on it.
    always_comb begin
        is_div   = op_reg[2];
        a_signed = is_div ? ~op_reg[0] : (op_reg != 3'b011);
        b_signed = is_div ? ~op_reg[0] : ~op_reg[1];
        sa       = a_signed & a_reg[WIDTH-1];
        sb       = b_signed & b_reg[WIDTH-1];
        mag_a_c  = sa ? (~a_reg + 1'b1) : a_reg;
        mag_b_c  = sb ? (~b_reg + 1'b1) : b_reg;
    end

    always_comb begin
        spec_hit = 1'b0;
        spec_val = '0;
        if (is_div && (b_reg == '0)) begin
            spec_hit = 1'b1;
            spec_val = op_reg[1] ? a_reg : '1;
        end else if (is_div && !op_reg[0] && (a_reg == {1'b1, {(WIDTH-1){1'b0}}}) && (b_reg == '1)) begin
            spec_hit = 1'b1;
            spec_val = op_reg[1] ? '0 : a_reg;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (!is_div && ((a_reg == '0) || (b_reg == '0))) begin
            spec_hit = 1'b1;
            spec_val = '0;
        end else if (is_div && (mag_a_c < mag_b_c)) begin
            spec_hit = 1'b1;
            spec_val = op_reg[1] ? a_reg : '0;
        end
`endif
    end

    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_d} : {(WIDTH+1){1'b0}});
        shifted = {rem, acc[WIDTH-1]};
        diff    = shifted - {1'b0, mag_d};
        ge      = (shifted >= {1'b0, mag_d});
    end

    always_comb begin
        prod_fix = neg_q ? (~acc + 1'b1) : acc;
        fix_val  = '0;
        case (op_reg)
            3'b000:                 fix_val = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_val = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
            default:                fix_val = neg_r ? (~rem + 1'b1) : rem;
        endcase
        load_val = (state == S_PREP) ? spec_val : fix_val;
        load_q   = !flush && (((state == S_PREP) && spec_hit) || (state == S_FIX));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start && !flush) state_nxt = S_PREP;
            S_PREP: begin
                if (flush)         state_nxt = S_IDLE;
                else if (spec_hit) state_nxt = S_DONE;
                else               state_nxt = S_ITER;
            end
            S_ITER: begin
                if (flush)                        state_nxt = S_IDLE;
                else if (cnt == CW'(WIDTH - 1))   state_nxt = S_FIX;
            end
            S_FIX:   state_nxt = flush ? S_IDLE : S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != S_IDLE);
        valid     = (state == S_DONE);
        dbg_state = state;
    end

    // For divides acc[WIDTH-1:0] holds the shifting dividend that becomes the quotient.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= '0;
            mag_d  <= '0;
            rem    <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            Q      <= '0;
        end else begin
            if ((state == S_IDLE) && start && !flush) begin
                a_reg  <= A;
                b_reg  <= B;
                op_reg <= op;
            end
            if (state == S_PREP) begin
                acc   <= is_div ? {{WIDTH{1'b0}}, mag_a_c} : {{WIDTH{1'b0}}, mag_b_c};
                mag_d <= is_div ? mag_b_c : mag_a_c;
                rem   <= '0;
                cnt   <= '0;
                neg_q <= sa ^ sb;
                neg_r <= sa;
            end
            if (state == S_ITER) begin
                cnt <= cnt + CW'(1);
                if (is_div) begin
                    rem <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ge};
                end else begin
                    acc <= {mul_sum, acc[WIDTH-1:1]};
                end
            end
            if (load_q) Q <= load_val;
        end
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative sequencer for the RV32M extension, enabled when the core is built with ENABLE_RV32_M=1. It sits beside the combinational ALU in the execute stage and accepts one operation per start handshake. It runs shift-add multiply or restoring divide over WIDTH iterations, applies sign correction, and returns a one-cycle valid result. The core stalls on busy.

Parameters:
WIDTH, 32, operand/result width. Iteration count equals WIDTH. Only 32 is verified.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted only in IDLE
op  input  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
A  input  WIDTH  rs1 operand; sampled on the accepting edge
B  input  WIDTH  rs2 operand; sampled on the accepting edge
flush  input  1  abort the in-flight operation (pipeline kill)
busy  output  1  high whenever state != IDLE
valid  output  1  one-cycle pulse; Q holds the result
Q  output  WIDTH  result register; holds its value until the next valid

Behaviour:
- Reset: rst_n=0 on a clock edge gives state=IDLE, busy=0, valid=0, Q=0, and clears all internal registers. Reset mid-operation discards the operation with no valid pulse.
- States: IDLE -> PREP -> ITER -> FIX -> DONE -> IDLE.
- IDLE: start=1 latches A, B and op, then goes to PREP. start=0 stays in IDLE.
- PREP (1 cycle): computes operand magnitudes. Signedness per op: MULH/DIV/REM treat A and B as signed. MULHSU treats A as signed and B as unsigned. MULHU/DIVU/REMU treat both as unsigned. MUL result is independent of sign. Records the result sign. Special cases go directly to DONE with the result loaded into Q:
  - Divide by zero (B=0, ops 1xx): DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - Signed overflow (DIV/REM with A=0x80000000 and B=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Otherwise go to ITER with the counter at 0.
- ITER (exactly WIDTH cycles, counter 0..WIDTH-1):
  - Multiply: one multiplier bit per cycle, LSB first, into a 2*WIDTH-bit product accumulator.
  - Divide: restoring; one quotient bit per cycle, MSB first, remainder WIDTH+1 bits.
  - Leaves to FIX when the counter reaches WIDTH-1.
- FIX (1 cycle):
  - Negate if the result sign is negative. Quotient sign = signA XOR signB; remainder sign = signA.
  - Select the result: MUL takes the low word. MULH/MULHSU/MULHU take the high word. DIV* takes the quotient. REM* takes the remainder.
  - Load Q.
- DONE (1 cycle): valid=1, then IDLE.
- Latency, with start high in cycle 0:
  - Normal path: PREP in cycle 1, ITER in cycles 2..33, FIX in cycle 34, valid in cycle 35.
  - Special case: valid in cycle 2.
- Throughput: a new start is accepted no earlier than the cycle after DONE, which is the cycle valid is low again.
- start while busy: ignored, not queued. A, B and op changes while busy have no effect.
- flush=1 in any state except IDLE: next state is IDLE, valid stays 0, Q is unchanged. Flush wins over a completion in the same cycle. flush in IDLE with start=1: start is ignored.
- Arithmetic is modulo 2^WIDTH. MUL low word is identical for signed and unsigned inputs.

Optional Feature:
Macro: MULDIV_EARLY_OUT_EN.
- Defined: PREP adds fast paths, all completing with valid in cycle 2:
  - Multiply ops with A=0 or B=0 give Q=0.
  - Divide ops with |A| < |B| (magnitudes per signedness) give quotient 0 and remainder A. A keeps its original sign, so no sign correction is applied.
- Not defined: these operands take the full 35-cycle path with identical numeric results.
- Results must be bit-identical with and without the macro; only latency differs.

Test Plan:
1. MUL with A=7, B=0xFFFFFFFD (-3) -> Q=0xFFFFFFEB, valid exactly in cycle 35, busy high in cycles 1..35.
2. High-word multiplies:
   - MULH with A=B=0x80000000 -> Q=0x40000000.
   - MULHU with A=B=0xFFFFFFFF -> Q=0xFFFFFFFE.
   - MULHSU with A=0xFFFFFFFF, B=0xFFFFFFFF -> Q=0xFFFFFFFF.
3. Divides:
   - DIV with A=-7, B=2 -> Q=0xFFFFFFFD (-3).
   - REM with A=-7, B=2 -> Q=0xFFFFFFFF (-1).
   - DIVU with A=0xFFFFFFFF, B=16 -> Q=0x0FFFFFFF.
   - REMU with A=0xFFFFFFFF, B=16 -> Q=0xF.
4. Divide by zero:
   - DIV with A=100, B=0 -> Q=0xFFFFFFFF.
   - REMU with A=100, B=0 -> Q=100.
   - Both give valid in cycle 2.
5. Signed overflow:
   - DIV with A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000.
   - REM with the same operands -> Q=0.
   - Both give valid in cycle 2.
6. Abort and reset:
   - DIVU accepted, flush in cycle 10 -> busy=0 in cycle 11, no valid, Q unchanged.
   - start held high throughout busy is ignored; the next start from IDLE completes normally.
   - rst_n=0 in cycle 20 of an operation -> all outputs 0 next cycle.
